// File: rtl/alu_seq.sv
// Registered ALU with a multi-cycle shift-add multiplier and a busy/done handshake.
// Build option ALU_SAT_EN: ADD/SUB saturate unsigned instead of wrapping.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; results and flags hold
// MUL     | one shift-add iteration per cycle, busy high
// DONE    | done high for one cycle, then back to IDLE unconditionally
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       SEL,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] OUT_HI,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V,
  output logic             ERR,
  output logic             busy,
  output logic             done
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH);
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;

  state_t state, state_next;

  logic [WIDTH:0]   sum, diff, shl_ext, shr_ext;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] res;
  logic             res_c, res_v, res_err;

  logic [2*WIDTH-1:0] acc, acc_next, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               mul_last;

  assign shamt   = B[SW-1:0];
  assign sum     = {1'b0, A} + {1'b0, B};
  assign diff    = {1'b0, A} - {1'b0, B};
  assign shl_ext = {1'b0, A} << shamt;
  assign shr_ext = {A, 1'b0} >> shamt;

  // Single-cycle result, evaluated directly on the inputs so it registers on the accepting edge.
  always_comb begin
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_err = 1'b0;
    case (SEL)
      4'd0: res = A & B;
      4'd1: res = A | B;
      4'd2: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
`ifdef ALU_SAT_EN
        if (sum[WIDTH]) res = '1;
`endif
      end
      4'd3: begin
        res   = diff[WIDTH-1:0];
        res_c = diff[WIDTH];
        res_v = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
`ifdef ALU_SAT_EN
        if (diff[WIDTH]) res = '0;
`endif
      end
      4'd4: res = A ^ B;
      4'd5: res = ~A;
      4'd6: begin
        res   = shl_ext[WIDTH-1:0];
        res_c = shl_ext[WIDTH];
      end
      4'd7: begin
        res   = shr_ext[WIDTH:1];
        res_c = shr_ext[0];
      end
      4'd8: res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'd9: res = '0;
      default: res_err = 1'b1;
    endcase
  end

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = (SEL == OP_MUL) ? ST_MUL : ST_DONE;
      ST_MUL:  if (mul_last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_MUL);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      OUT    <= '0;
      OUT_HI <= '0;
      Z      <= 1'b0;
      N      <= 1'b0;
      C      <= 1'b0;
      V      <= 1'b0;
      ERR    <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (SEL == OP_MUL) begin
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, A};
              mplier <= B;
              cnt    <= CW'(WIDTH - 1);
            end else begin
              OUT    <= res;
              OUT_HI <= '0;
              Z      <= (res == '0);
              N      <= res[WIDTH-1];
              C      <= res_c;
              V      <= res_v;
              ERR    <= res_err;
            end
          end
        end
        ST_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
          if (mul_last) begin
            OUT    <= acc_next[WIDTH-1:0];
            OUT_HI <= acc_next[2*WIDTH-1:WIDTH];
            Z      <= (acc_next == '0);
            N      <= acc_next[WIDTH-1];
            C      <= 1'b0;
            V      <= 1'b0;
            ERR    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
